// File: rtl/anti_theft_fsm_pkg.sv
// Shared definitions for the vehicle anti-theft controller: state codes as
// shown on the display, timer interval select codes, and state classifiers.
package anti_theft_fsm_pkg;

  typedef enum logic [2:0] {
    ST_ARMED       = 3'd0,
    ST_TRIGGERED   = 3'd1,
    ST_SOUND_ALARM = 3'd2,
    ST_ALARM_HOLD  = 3'd3,
    ST_DISARMED    = 3'd4,
    ST_WAIT_OPEN   = 3'd5,
    ST_WAIT_CLOSE  = 3'd6,
    ST_ARMING      = 3'd7
  } state_e;

  localparam logic [1:0] IV_ARM_DELAY       = 2'b00;
  localparam logic [1:0] IV_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] IV_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] IV_ALARM_ON        = 2'b11;

  // States that run an external countdown while resident.
  function automatic logic is_timed(input state_e s);
    return (s == ST_TRIGGERED) || (s == ST_ALARM_HOLD) || (s == ST_ARMING);
  endfunction

  // States in which the siren generator runs.
  function automatic logic is_siren(input state_e s);
    return (s == ST_SOUND_ALARM) || (s == ST_ALARM_HOLD);
  endfunction

  // States in which the status LED is lit solid.
  function automatic logic is_led_solid(input state_e s);
    return (s == ST_TRIGGERED) || (s == ST_SOUND_ALARM) || (s == ST_ALARM_HOLD);
  endfunction

endpackage

// File: rtl/anti_theft_fsm_status_blinker.sv
// Blink phase generator for the status LED while the system is armed.
// The blink output presents the phase that will hold after the coming edge,
// so the parent can register it alongside its own state update.
module status_blinker (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic one_hz_enable,
  input  logic clear,
  output logic blink
);

  logic phase_q;
  logic phase_d;

  // Next phase: clear forces 0, otherwise toggle on each 1 Hz strobe when enabled.
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = 1'b0;
    end else if (enable && one_hz_enable) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign blink = phase_d;

endmodule

// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft controller: arms after the doors close, raises an
// alarm on intrusion, and is disarmed by the ignition. Every output is a
// flop updated on the same edge as the state, so estado and the outputs
// always describe the same state.
module anti_theft_fsm
  import anti_theft_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic [1:0] interval,
  output logic       start_timer,
  output logic       eneble_siren,
  output logic       status,
  output logic [2:0] estado
);

  state_e     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic       start_q, start_d;
  logic       siren_q, siren_d;
  logic       status_q, status_d;

  logic door_open_s;
  logic doors_closed_s;
  logic expired_ok_s;
  logic blink_s;
  logic blink_en_s;
  logic blink_clr_s;

  assign door_open_s    = door_driver | door_pass;
  assign doors_closed_s = ~door_open_s;
  // The timer is just being loaded in the start cycle, so a stale pulse there is dropped.
  assign expired_ok_s   = expired & ~start_q;

  // Next-state logic; ignition beats doors, doors beat expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: begin
        if (door_open_s) state_d = ST_TRIGGERED;
        else             state_d = state_q;
      end
      ST_TRIGGERED: begin
        if (ignition)          state_d = ST_DISARMED;
        else if (expired_ok_s) state_d = ST_SOUND_ALARM;
        else                   state_d = state_q;
      end
      ST_SOUND_ALARM: begin
        if (ignition)            state_d = ST_DISARMED;
        else if (doors_closed_s) state_d = ST_ALARM_HOLD;
        else                     state_d = state_q;
      end
      ST_ALARM_HOLD: begin
        if (ignition)          state_d = ST_DISARMED;
        else if (door_open_s)  state_d = ST_SOUND_ALARM;
        else if (expired_ok_s) state_d = ST_ARMED;
        else                   state_d = state_q;
      end
      ST_DISARMED: begin
        if (!ignition) state_d = ST_WAIT_OPEN;
        else           state_d = state_q;
      end
      ST_WAIT_OPEN: begin
        if (ignition)         state_d = ST_DISARMED;
        else if (door_driver) state_d = ST_WAIT_CLOSE;
        else                  state_d = state_q;
      end
      ST_WAIT_CLOSE: begin
        if (ignition)            state_d = ST_DISARMED;
        else if (doors_closed_s) state_d = ST_ARMING;
        else                     state_d = state_q;
      end
      ST_ARMING: begin
        if (ignition)          state_d = ST_DISARMED;
        else if (door_open_s)  state_d = ST_WAIT_CLOSE;
        else if (expired_ok_s) state_d = ST_ARMED;
        else                   state_d = state_q;
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // Blink only while staying in ARMED; any entry or exit restarts the phase at 0.
  assign blink_en_s  = (state_q == ST_ARMED);
  assign blink_clr_s = (state_q != ST_ARMED) | (state_d != ST_ARMED);

  status_blinker u_blinker (
    .clock         (clock),
    .reset         (reset),
    .enable        (blink_en_s),
    .one_hz_enable (one_hz_enable),
    .clear         (blink_clr_s),
    .blink         (blink_s)
  );

  // Output values for the state being entered on this edge.
  always_comb begin
    interval_d = IV_ARM_DELAY;
    case (state_d)
      ST_TRIGGERED: begin
        // The delay is chosen by whichever door tripped the alarm and held thereafter.
        if (state_q == ST_TRIGGERED) interval_d = interval_q;
        else if (door_driver)        interval_d = IV_DRIVER_DELAY;
        else                         interval_d = IV_PASSENGER_DELAY;
      end
      ST_ALARM_HOLD: interval_d = IV_ALARM_ON;
      ST_ARMING:     interval_d = IV_ARM_DELAY;
      default:       interval_d = IV_ARM_DELAY;
    endcase

    start_d = is_timed(state_d) && (state_d != state_q);
    siren_d = is_siren(state_d);

    if (state_d == ST_ARMED) status_d = blink_s;
    else                     status_d = is_led_solid(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      interval_q <= IV_ARM_DELAY;
      start_q    <= 1'b0;
      siren_q    <= 1'b0;
      status_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      start_q    <= start_d;
      siren_q    <= siren_d;
      status_q   <= status_d;
    end
  end

  assign estado       = state_q;
  assign interval     = interval_q;
  assign start_timer  = start_q;
  assign eneble_siren = siren_q;
  assign status       = status_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Bench for anti_theft_fsm: a directed vector table walking the documented
// scenarios, a hand-written reset sequence, then randomized inputs checked
// against a rule-level reference model.
module tb_anti_theft_fsm;

  logic       clock = 1'b0;
  logic       reset, ignition, door_driver, door_pass, expired, one_hz_enable;
  logic [1:0] interval;
  logic       start_timer, eneble_siren, status;
  logic [2:0] estado;

  int n_checks = 0;
  int n_fails  = 0;

  anti_theft_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .ignition      (ignition),
    .door_driver   (door_driver),
    .door_pass     (door_pass),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .interval      (interval),
    .start_timer   (start_timer),
    .eneble_siren  (eneble_siren),
    .status        (status),
    .estado        (estado)
  );

  always #5 clock = ~clock;

  // in = {reset, ignition, door_driver, door_pass, expired, one_hz_enable}
  typedef struct packed {
    logic [5:0] in;
    logic [2:0] est;
    logic [1:0] iv;
    logic       st;
    logic       sir;
    logic       led;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] in, input logic [2:0] est, input logic [1:0] iv,
                     input logic st, input logic sir, input logic led);
    vec_t v;
    v.in = in; v.est = est; v.iv = iv; v.st = st; v.sir = sir; v.led = led;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] in);
    {reset, ignition, door_driver, door_pass, expired, one_hz_enable} = in;
  endtask

  // exp = {estado, interval, start_timer, eneble_siren, status}
  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {estado, interval, start_timer, eneble_siren, status};
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got estado=%0d interval=%b start=%b siren=%b status=%b, want estado=%0d interval=%b start=%b siren=%b status=%b",
               name, act[7:5], act[4:3], act[2], act[1], act[0],
               exp[7:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input string name, input logic [5:0] in, input logic [7:0] exp);
    drive(in);
    @(posedge clock);
    #1;
    check(name, exp);
  endtask

  // ---------------- reference model ----------------
  // State numbers are the display codes; status in ARMED is the parity of
  // strobes counted since entering ARMED.
  int m_state, m_interval, m_trig_iv, m_blinks;
  bit m_start, m_siren, m_status;

  task automatic model_reset();
    m_state = 0; m_interval = 0; m_trig_iv = 0; m_blinks = 0;
    m_start = 1'b0; m_siren = 1'b0; m_status = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit ign, input bit dd, input bit dp,
                            input bit ex, input bit hz);
    int  nxt;
    bit  door, ex_ok;
    if (r) begin
      model_reset();
      return;
    end
    door  = dd | dp;
    ex_ok = ex && !m_start;
    nxt   = m_state;
    case (m_state)
      0: if (door) nxt = 1;
      1: if (ign) nxt = 4; else if (ex_ok) nxt = 2;
      2: if (ign) nxt = 4; else if (!door) nxt = 3;
      3: if (ign) nxt = 4; else if (door) nxt = 2; else if (ex_ok) nxt = 0;
      4: if (!ign) nxt = 5;
      5: if (ign) nxt = 4; else if (dd) nxt = 6;
      6: if (ign) nxt = 4; else if (!door) nxt = 7;
      7: if (ign) nxt = 4; else if (door) nxt = 6; else if (ex_ok) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt == 1 && m_state != 1) m_trig_iv = dd ? 1 : 2;
    if (nxt == 0 && m_state == 0) m_blinks = m_blinks + (hz ? 1 : 0);
    else                          m_blinks = 0;
    m_start    = (nxt == 1 || nxt == 3 || nxt == 7) && (nxt != m_state);
    m_interval = (nxt == 1) ? m_trig_iv : (nxt == 3) ? 3 : 0;
    m_siren    = (nxt == 2 || nxt == 3);
    m_status   = (nxt == 0) ? (m_blinks % 2 == 1) : (nxt >= 1 && nxt <= 3);
    m_state    = nxt;
  endtask

  function automatic logic [7:0] model_vec();
    return {3'(m_state), 2'(m_interval), m_start, m_siren, m_status};
  endfunction

  initial begin
    bit ign_hold, r, dd, dp, ex, hz;
    drive(6'b100000);

    // Reset, driver intrusion, timeout to siren, hold and re-trigger, rearm.
    add(6'b100000, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b001000, 3'd1, 2'b01, 1'b1, 1'b0, 1'b1);
    add(6'b000000, 3'd1, 2'b01, 1'b0, 1'b0, 1'b1);
    add(6'b000010, 3'd2, 2'b00, 1'b0, 1'b1, 1'b1);
    add(6'b000000, 3'd3, 2'b11, 1'b1, 1'b1, 1'b1);
    add(6'b000100, 3'd2, 2'b00, 1'b0, 1'b1, 1'b1);
    add(6'b000000, 3'd3, 2'b11, 1'b1, 1'b1, 1'b1);
    add(6'b000000, 3'd3, 2'b11, 1'b0, 1'b1, 1'b1);
    add(6'b000010, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    // Blinking in ARMED, expired and ignition ignored there.
    add(6'b000001, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    add(6'b000001, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000001, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    add(6'b000001, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000010, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b010000, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    // Passenger intrusion, expired in start cycle ignored, ignition disarms.
    add(6'b000100, 3'd1, 2'b10, 1'b1, 1'b0, 1'b1);
    add(6'b000010, 3'd1, 2'b10, 1'b0, 1'b0, 1'b1);
    add(6'b010000, 3'd4, 2'b00, 1'b0, 1'b0, 1'b0);
    // Arming path with an interrupted countdown.
    add(6'b010000, 3'd4, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000000, 3'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000100, 3'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b001000, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b001000, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000000, 3'd7, 2'b00, 1'b1, 1'b0, 1'b0);
    add(6'b001000, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000000, 3'd7, 2'b00, 1'b1, 1'b0, 1'b0);
    add(6'b000000, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b001010, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000000, 3'd7, 2'b00, 1'b1, 1'b0, 1'b0);
    add(6'b000000, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000010, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    // Reset during a countdown, blink phase restarts, both doors pick driver delay.
    add(6'b001000, 3'd1, 2'b01, 1'b1, 1'b0, 1'b1);
    add(6'b000000, 3'd1, 2'b01, 1'b0, 1'b0, 1'b1);
    add(6'b100010, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6'b000001, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    add(6'b001100, 3'd1, 2'b01, 1'b1, 1'b0, 1'b1);
    add(6'b010000, 3'd4, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].in,
           {vecs[i].est, vecs[i].iv, vecs[i].st, vecs[i].sir, vecs[i].led});
    end

    // Hand sequence: reset held with doors open, then reset in ALARM_HOLD countdown.
    step("rst_doors_a", 6'b101100, 8'b000_00_0_0_0);
    step("rst_doors_b", 6'b101100, 8'b000_00_0_0_0);
    step("rel_armed",   6'b000000, 8'b000_00_0_0_0);
    step("trip_pass",   6'b000100, 8'b001_10_1_0_1);
    step("trip_wait",   6'b000000, 8'b001_10_0_0_1);
    step("trip_exp",    6'b000010, 8'b010_00_0_1_1);
    step("hold_enter",  6'b000000, 8'b011_11_1_1_1);
    step("hold_count",  6'b000000, 8'b011_11_0_1_1);
    step("hold_reset",  6'b100001, 8'b000_00_0_0_0);
    step("hold_ign",    6'b000100, 8'b001_10_1_0_1);

    // Randomized run against the reference model.
    step("rand_reset", 6'b100000, 8'b000_00_0_0_0);
    model_reset();
    ign_hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) ign_hold = ~ign_hold;
      r  = ($urandom_range(0, 299) == 0);
      dd = ($urandom_range(0, 4) == 0);
      dp = ($urandom_range(0, 4) == 0);
      ex = ($urandom_range(0, 3) == 0);
      hz = ($urandom_range(0, 4) == 0);
      drive({r, ign_hold, dd, dp, ex, hz});
      @(posedge clock);
      #1;
      model_step(r, ign_hold, dd, dp, ex, hz);
      check($sformatf("rand%0d", c), model_vec());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
